// File: rtl/muldiv_issue_ctrl.sv
// Issue controller for the shared combinational multiply/divide unit.
// Arbitrates two issue lanes round-robin, holds operands for a fixed budget, returns a fixed-up result.
module muldiv_issue_ctrl #(
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 8,
    parameter int TAG_W   = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_operand1,
    input  logic [31:0]      req0_operand2,
    input  logic [4:0]       req0_execute_type,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_operand1,
    input  logic [31:0]      req1_operand2,
    input  logic [4:0]       req1_execute_type,
    input  logic [TAG_W-1:0] req1_tag,
    output logic [31:0]      md_operand1,
    output logic [31:0]      md_operand2,
    output logic [4:0]       md_execute_type,
    input  logic [31:0]      md_result,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [31:0]      wb_result,
    output logic [TAG_W-1:0] wb_tag,
    output logic             busy
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             last_grant_reg;
    logic [TAG_W-1:0] tag_reg;
    logic [31:0]      md_operand1_reg;
    logic [31:0]      md_operand2_reg;
    logic [4:0]       md_execute_type_reg;
    logic             wb_valid_reg;
    logic [31:0]      wb_result_reg;
    logic [TAG_W-1:0] wb_tag_reg;

    logic             grant0;
    logic             grant1;
    logic             accept_open;
    logic             accept;
    logic [31:0]      sel_operand1;
    logic [31:0]      sel_operand2;
    logic [4:0]       sel_execute_type;
    logic [TAG_W-1:0] sel_tag;
    logic [CNT_W-1:0] sel_cnt;
    logic [31:0]      capture_result;

    // Under contention the lane that did not win last time goes first.
    assign grant0      = req0_valid & (~req1_valid | last_grant_reg);
    assign grant1      = req1_valid & (~req0_valid | ~last_grant_reg);
    assign accept_open = (state_reg == IDLE) & ~flush & ~rst;
    assign req0_ready  = accept_open & grant0;
    assign req1_ready  = accept_open & grant1;
    assign accept      = req0_ready | req1_ready;

    always_comb begin
        sel_operand1     = req0_operand1;
        sel_operand2     = req0_operand2;
        sel_execute_type = req0_execute_type;
        sel_tag          = req0_tag;
        if (req1_ready) begin
            sel_operand1     = req1_operand1;
            sel_operand2     = req1_operand2;
            sel_execute_type = req1_execute_type;
            sel_tag          = req1_tag;
        end
        // Only mul/mulh use the short budget; everything else, unknown types included, uses the long one.
        if (sel_execute_type[4:1] == 4'd0) begin
            sel_cnt = CNT_W'(MUL_LAT - 1);
        end else begin
            sel_cnt = CNT_W'(DIV_LAT - 1);
        end
    end

    // RISC-V divide-by-zero semantics are applied here rather than trusted to the unit.
    always_comb begin
        capture_result = md_result;
        if (md_execute_type_reg[4:2] != 3'd0) begin
            capture_result = 32'd0;
        end else if (md_execute_type_reg[1] && (md_operand2_reg == 32'd0)) begin
            capture_result = md_execute_type_reg[0] ? md_operand1_reg : 32'hFFFF_FFFF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg           <= IDLE;
            cnt_reg             <= '0;
            last_grant_reg      <= 1'b1;
            tag_reg             <= '0;
            md_operand1_reg     <= '0;
            md_operand2_reg     <= '0;
            md_execute_type_reg <= '0;
            wb_valid_reg        <= 1'b0;
            wb_result_reg       <= '0;
            wb_tag_reg          <= '0;
        end else if (flush) begin
            state_reg    <= IDLE;
            wb_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        md_operand1_reg     <= sel_operand1;
                        md_operand2_reg     <= sel_operand2;
                        md_execute_type_reg <= sel_execute_type;
                        tag_reg             <= sel_tag;
                        last_grant_reg      <= req1_ready;
                        cnt_reg             <= sel_cnt;
                        state_reg           <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt_reg == '0) begin
                        wb_result_reg <= capture_result;
                        wb_tag_reg    <= tag_reg;
                        wb_valid_reg  <= 1'b1;
                        state_reg     <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                DONE: begin
                    if (wb_ready) begin
                        wb_valid_reg <= 1'b0;
                        state_reg    <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign md_operand1     = md_operand1_reg;
    assign md_operand2     = md_operand2_reg;
    assign md_execute_type = md_execute_type_reg;
    assign wb_valid        = wb_valid_reg;
    assign wb_result       = wb_result_reg;
    assign wb_tag          = wb_tag_reg;
    assign busy            = (state_reg != IDLE);

endmodule
